// File: rtl/mbox_cycle_seq_pkg.sv
// Shared types for the EBOX memory-cycle sequencer: state encoding, held
// cycle-type record and the default MBOX no-response limit.
package mbox_cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_RPW_HOLD,
    ST_PF,
    ST_NXM
  } mcs_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic pause;
    logic fetch;
    logic ldar;
    logic ldarx;
  } mcs_cyc_t;

  localparam int MCS_TIMEOUT_DEFAULT = 1023;

  // States in which the EBOX clock must be held off.
  function automatic logic mcs_stalls(input mcs_state_t s);
    return (s == ST_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_WAIT) ||
           (s == ST_PF)  || (s == ST_NXM);
  endfunction

endpackage

// File: rtl/mbox_cycle_seq_if.sv
// MCL request / MBOX handshake bundle. The sequencer uses the master modport;
// the surrounding EBOX/MBOX logic (or a bench) uses the slave modport.
interface mbox_cycle_seq_if;
  logic MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, VMA_FETCH, LOAD_AR, LOAD_ARX;
  logic MB_ACK, MB_DATA_VALID, MB_WR_TAKEN, PAGE_FAIL;
  logic MB_REQ, MB_RD, MB_WR, RPW_LOCK, MEM_WAIT;
  logic AR_LOAD, ARX_LOAD, FETCH_DONE, PF_TRAP, NXM_ERR, SEQ_ERR;

  modport master (
    input  MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, VMA_FETCH, LOAD_AR, LOAD_ARX,
    input  MB_ACK, MB_DATA_VALID, MB_WR_TAKEN, PAGE_FAIL,
    output MB_REQ, MB_RD, MB_WR, RPW_LOCK, MEM_WAIT,
    output AR_LOAD, ARX_LOAD, FETCH_DONE, PF_TRAP, NXM_ERR, SEQ_ERR
  );

  modport slave (
    output MBOX_CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, VMA_FETCH, LOAD_AR, LOAD_ARX,
    output MB_ACK, MB_DATA_VALID, MB_WR_TAKEN, PAGE_FAIL,
    input  MB_REQ, MB_RD, MB_WR, RPW_LOCK, MEM_WAIT,
    input  AR_LOAD, ARX_LOAD, FETCH_DONE, PF_TRAP, NXM_ERR, SEQ_ERR
  );
endinterface

// File: rtl/mbox_cycle_seq_watchdog.sv
// MBOX no-response watchdog: cleared on entry to a wait state, counts while
// waiting, flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module mbox_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mbox_cycle_seq.sv
// EBOX memory-cycle sequencer between MCL request decode and the MBOX handshake.
// Optional MBOX no-response watchdog enabled by defining MBOX_CYC_SEQ_TIMEOUT_EN.
module mbox_cycle_seq
  import mbox_cycle_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MCS_TIMEOUT_DEFAULT,
  parameter int TO_W           = 10
) (
  input  logic              clk,
  input  logic              RESET_N,
  mbox_cycle_seq_if.master  bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || (TIMEOUT_CYCLES >> TO_W) != 0) begin : g_bad_cfg
    $error("mbox_cycle_seq: TIMEOUT_CYCLES must be 2..65535 and below 2**TO_W");
  end

  mcs_state_t state_q, state_d;
  mcs_cyc_t   cyc_q, cyc_d;
  logic       done_q, done_d;        // RD_WAIT: data arrived, load pulses this cycle
  logic       seq_err_q, seq_err_d;
  logic       expired;

`ifdef MBOX_CYC_SEQ_TIMEOUT_EN
  logic wd_en, wd_clr;
  assign wd_en  = (state_q == ST_REQ) || (state_q == ST_WR_WAIT) ||
                  ((state_q == ST_RD_WAIT) && !done_q);
  assign wd_clr = (state_d != state_q);

  mbox_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wdog (
    .clk       (clk),
    .rst_n     (RESET_N),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    done_d    = 1'b0;
    seq_err_d = seq_err_q;

    if (bus.MBOX_CYC_REQ &&
        (state_q == ST_REQ || state_q == ST_RD_WAIT || state_q == ST_WR_WAIT))
      seq_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.MBOX_CYC_REQ && (bus.VMA_READ || bus.VMA_WRITE)) begin
          cyc_d.rd    = bus.VMA_READ;
          cyc_d.wr    = bus.VMA_WRITE;
          cyc_d.pause = bus.VMA_PAUSE;
          cyc_d.fetch = bus.VMA_FETCH;
          cyc_d.ldar  = bus.LOAD_AR;
          cyc_d.ldarx = bus.LOAD_ARX;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.PAGE_FAIL)   state_d = ST_PF;
        else if (bus.MB_ACK) state_d = cyc_q.rd ? ST_RD_WAIT : ST_WR_WAIT;
        else if (expired) begin
          state_d   = ST_NXM;
          seq_err_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (done_q)                 state_d = cyc_q.pause ? ST_RPW_HOLD : ST_IDLE;
        else if (bus.PAGE_FAIL)     state_d = ST_PF;
        else if (bus.MB_DATA_VALID) done_d  = 1'b1;
        else if (expired) begin
          state_d   = ST_NXM;
          seq_err_d = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (bus.PAGE_FAIL)        state_d = ST_PF;
        else if (bus.MB_WR_TAKEN) state_d = ST_IDLE;
        else if (expired) begin
          state_d   = ST_NXM;
          seq_err_d = 1'b1;
        end
      end
      ST_RPW_HOLD: begin
        if (bus.PAGE_FAIL) state_d = ST_PF;
        else if (bus.MBOX_CYC_REQ && bus.VMA_WRITE) begin
          // Write half of RPW: the read already happened, so issue a pure write.
          cyc_d.rd    = 1'b0;
          cyc_d.wr    = 1'b1;
          cyc_d.pause = bus.VMA_PAUSE;
          cyc_d.fetch = bus.VMA_FETCH;
          cyc_d.ldar  = bus.LOAD_AR;
          cyc_d.ldarx = bus.LOAD_ARX;
          state_d     = ST_REQ;
        end else if (bus.MBOX_CYC_REQ && bus.VMA_READ) begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PF:   state_d = ST_IDLE;
      ST_NXM:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
      seq_err_q <= seq_err_d;
    end
  end

  logic deliver;
  assign deliver = (state_q == ST_RD_WAIT) && done_q;

  assign bus.MB_REQ     = (state_q == ST_REQ);
  assign bus.MB_RD      = bus.MB_REQ && cyc_q.rd;
  assign bus.MB_WR      = bus.MB_REQ && cyc_q.wr && !cyc_q.rd;
  assign bus.RPW_LOCK   = (state_q == ST_RPW_HOLD);
  assign bus.MEM_WAIT   = mcs_stalls(state_q);
  assign bus.AR_LOAD    = deliver && cyc_q.ldar;
  assign bus.ARX_LOAD   = deliver && cyc_q.ldarx;
  assign bus.FETCH_DONE = deliver && cyc_q.fetch;
  assign bus.PF_TRAP    = (state_q == ST_PF);
`ifdef MBOX_CYC_SEQ_TIMEOUT_EN
  assign bus.NXM_ERR    = (state_q == ST_NXM);
`else
  assign bus.NXM_ERR    = 1'b0;
`endif
  assign bus.SEQ_ERR    = seq_err_q;

endmodule

// File: tb/tb_mbox_cycle_seq.sv
// Bench for mbox_cycle_seq: directed scenarios plus randomized transactions whose
// expected per-cycle outputs are derived from transaction-level timing rules.
module tb_mbox_cycle_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic RESET_N;

  mbox_cycle_seq_if bus();

  mbox_cycle_seq #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, rd, wr, pause, fetch, ldar, ldarx, ack, dv, taken, pf;
  } stim_t;

  typedef struct packed {
    logic mreq, mrd, mwr, lock, wt, ar, arx, fd, pft, nxm, serr;
  } obs_t;

  stim_t sq[$];
  obs_t  eq[$];
  int    checks = 0;
  int    errors = 0;
  logic  serr_m = 1'b0;

  function automatic obs_t ob(input logic mreq, mrd, mwr, lock, wt, ar, arx, fd, pft, nxm);
    obs_t o;
    o = '{mreq, mrd, mwr, lock, wt, ar, arx, fd, pft, nxm, serr_m};
    return o;
  endfunction

  function automatic obs_t ob0();
    return ob(L, L, L, L, L, L, L, L, L, L);
  endfunction

  // Random values on inputs that the current phase is required to ignore.
  function automatic stim_t noise();
    stim_t s;
    s       = '0;
    s.rd    = 1'($urandom);
    s.wr    = 1'($urandom);
    s.pause = 1'($urandom);
    s.fetch = 1'($urandom);
    s.ldar  = 1'($urandom);
    s.ldarx = 1'($urandom);
    s.ack   = 1'($urandom);
    s.dv    = 1'($urandom);
    s.taken = 1'($urandom);
    return s;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = '{bus.MB_REQ, bus.MB_RD, bus.MB_WR, bus.RPW_LOCK, bus.MEM_WAIT, bus.AR_LOAD,
          bus.ARX_LOAD, bus.FETCH_DONE, bus.PF_TRAP, bus.NXM_ERR, bus.SEQ_ERR};
    return o;
  endfunction

  task automatic put(input stim_t s, input obs_t o);
    sq.push_back(s);
    eq.push_back(o);
  endtask

  task automatic drive(input stim_t s);
    bus.MBOX_CYC_REQ  = s.req;
    bus.VMA_READ      = s.rd;
    bus.VMA_WRITE     = s.wr;
    bus.VMA_PAUSE     = s.pause;
    bus.VMA_FETCH     = s.fetch;
    bus.LOAD_AR       = s.ldar;
    bus.LOAD_ARX      = s.ldarx;
    bus.MB_ACK        = s.ack;
    bus.MB_DATA_VALID = s.dv;
    bus.MB_WR_TAKEN   = s.taken;
    bus.PAGE_FAIL     = s.pf;
  endtask

  task automatic check(input string tag, input int cyc, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d: got req/rd/wr/lock/wait/ar/arx/fd/pf/nxm/serr=%b expected %b",
             tag, cyc, got, exp);
    end
  endtask

  // One queued entry per clock: drive after the edge, compare on the falling edge.
  task automatic run_q(input string tag);
    for (int i = 0; i < sq.size(); i++) begin
      @(posedge clk); #1;
      drive(sq[i]);
      @(negedge clk);
      check(tag, i, dut_obs(), eq[i]);
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    drive('0);
    RESET_N = 1'b0;
    #1;
    serr_m = 1'b0;
    check(tag, 0, dut_obs(), ob0());
    @(negedge clk);
    RESET_N = 1'b1;
  endtask

  // Wait region of one MBOX cycle: a+1 request cycles (ack on the last),
  // then d+1 response-wait cycles (response on the last). pf_at >= 0 aborts there.
  task automatic gen_wait(input logic is_rd, input int a, input int d, input int pf_at,
                          output logic aborted);
    stim_t s;
    obs_t  o;
    aborted = 1'b0;
    for (int j = 0; j <= a + 1 + d; j++) begin
      s = noise();
      if (j <= a) begin
        s.ack = (j == a);
        o = ob(H, is_rd, !is_rd, L, H, L, L, L, L, L);
      end else begin
        if (is_rd) s.dv = (j == a + 1 + d);
        else       s.taken = (j == a + 1 + d);
        o = ob(L, L, L, L, H, L, L, L, L, L);
      end
      if (j == pf_at) begin
        s.pf = H;
        put(s, o);
        put(noise(), ob(L, L, L, L, H, L, L, L, H, L));
        aborted = 1'b1;
        return;
      end
      put(s, o);
    end
  endtask

  // kind 0: read, 1: write, 2: read-pause-write with h hold cycles.
  task automatic gen_txn(input int kind, input int a, input int d, input int w, input int h,
                         input int pf_rd, input int pf_wr);
    stim_t s;
    logic  ab, fe, la, lx;
    fe = 1'($urandom);
    la = 1'($urandom);
    lx = 1'($urandom);
    if (kind != 1) begin
      s       = noise();
      s.req   = H;
      s.rd    = H;
      s.pause = (kind == 2);
      s.fetch = fe;
      s.ldar  = la;
      s.ldarx = lx;
      s.pf    = 1'($urandom);
      put(s, ob0());
      gen_wait(H, a, d, pf_rd, ab);
      if (ab) return;
      put(noise(), ob(L, L, L, L, H, la, lx, fe, L, L));
      if (kind == 0) return;
      for (int k = 0; k < h; k++) begin
        s = noise();
        s.req = (k == h - 1);
        s.wr  = s.wr | (k == h - 1);
        if (k != h - 1) s.req = L;
        put(s, ob(L, L, L, H, L, L, L, L, L, L));
      end
    end else begin
      s       = noise();
      s.req   = H;
      s.rd    = L;
      s.wr    = H;
      s.pause = L;
      s.pf    = 1'($urandom);
      put(s, ob0());
    end
    gen_wait(L, a, w, pf_wr, ab);
  endtask

  initial begin
    stim_t s;
    RESET_N = 1'b0;
    drive('0);
    #2;
    check("reset", 0, dut_obs(), ob0());
    @(negedge clk);
    RESET_N = 1'b1;

    // Plain read: ack in cycle 2, data in cycle 4.
    for (int c = 0; c < 8; c++) begin
      s = '0;
      s.req = (c == 0); s.rd = (c == 0); s.ldar = (c == 0);
      s.ack = (c == 2); s.dv = (c == 4);
      put(s, ob(c inside {[1:2]}, c inside {[1:2]}, L, L, c inside {[1:5]},
                c == 5, L, L, L, L));
    end
    run_q("plain_rd");

    // Read-pause-write, write request on the third hold cycle.
    gen_txn(2, 0, 0, 1, 3, -1, -1);
    put('0, ob0());
    run_q("rpw");

    // Page fail together with the write ack.
    for (int c = 0; c < 6; c++) begin
      s = '0;
      s.req = (c == 0); s.wr = (c == 0);
      s.ack = (c == 2); s.pf = (c == 2); s.taken = (c == 4);
      put(s, ob(c inside {[1:2]}, L, c inside {[1:2]}, L, c inside {[1:3]},
                L, L, L, c == 3, L));
    end
    run_q("pf_ack");

    // Second request while waiting for read data.
    for (int c = 0; c < 8; c++) begin
      s = '0;
      s.req   = (c == 0) || (c == 2);
      s.rd    = (c == 0) || (c == 2);
      s.wr    = (c == 2);
      s.ldar  = (c == 2);
      s.ldarx = (c == 0);
      s.fetch = (c == 0);
      s.ack   = (c == 1);
      s.dv    = (c == 3);
      put(s, ob(c == 1, c == 1, L, L, c inside {[1:4]}, L, c == 4, c == 4, L, L));
      if (c == 2) serr_m = H;
    end
    run_q("busy");
    do_reset("serr_clr");

`ifdef MBOX_CYC_SEQ_TIMEOUT_EN
    for (int c = 0; c < 12; c++) begin
      s = '0;
      s.req = (c == 0); s.wr = (c == 0);
      if (c == 9) serr_m = H;
      put(s, ob(c inside {[1:8]}, L, c inside {[1:8]}, L, c inside {[1:9]},
                L, L, L, L, c == 9));
    end
    run_q("timeout");
`else
    for (int c = 0; c < 16; c++) begin
      s = '0;
      s.req = (c == 0); s.wr = (c == 0);
      put(s, ob(c >= 1, L, c >= 1, L, c >= 1, L, L, L, L, L));
    end
    run_q("no_timeout");
`endif
    do_reset("rst_to");

    // Asynchronous reset in RD_WAIT, then late read data.
    for (int c = 0; c < 3; c++) begin
      s = '0;
      s.req = (c == 0); s.rd = (c == 0); s.ldar = (c == 0); s.ack = (c == 1);
      put(s, ob(c == 1, c == 1, L, L, c >= 1, L, L, L, L, L));
    end
    run_q("arst_pre");
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_now", 0, dut_obs(), ob0());
    @(posedge clk); #1;
    s = '0; s.dv = H;
    drive(s);
    @(negedge clk);
    RESET_N = 1'b1;
    for (int c = 0; c < 3; c++) put(s, ob0());
    run_q("arst_post");

    // Randomized transactions with ignored-input noise and idle gaps.
    for (int t = 0; t < 40; t++) begin
      int kind, a, d, w, h, pr, pw, gap;
      kind = int'($urandom_range(2, 0));
      a    = int'($urandom_range(4, 0));
      d    = int'($urandom_range(4, 0));
      w    = int'($urandom_range(4, 0));
      h    = int'($urandom_range(3, 1));
      pr   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(a + 1 + d, 0)) : -1;
      pw   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(a + 1 + w, 0)) : -1;
      gen_txn(kind, a, d, w, h, pr, pw);
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) begin
        s = noise();
        s.req = 1'($urandom);
        s.rd  = L;
        s.wr  = L;
        s.pf  = 1'($urandom);
        put(s, ob0());
      end
    end
    put('0, ob0());
    run_q("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
